// File: rtl/irq_button_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// irq_button_ctrl_pkg
// Shared definitions for the push-button interrupt front end. It lives next to
// pacoblaze_inc.v so that other button/switch front ends can reuse the state
// encodings and the default debounce timing.
//   deb_state_t : debounce FSM state (2-bit encoding)
//   irq_state_t : interrupt request FSM state
//   DEBOUNCE_CYCLES_DEFAULT / CNT_W_DEFAULT : 10 ms at 32 MHz
// -----------------------------------------------------------------------------
package irq_button_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        CHK_HIGH  = 2'd1,
        IDLE_HIGH = 2'd2,
        CHK_LOW   = 2'd3
    } deb_state_t;

    typedef enum logic {
        IRQ_IDLE = 1'b0,
        IRQ_PEND = 1'b1
    } irq_state_t;

    // 10 ms at 32 MHz; the counter must hold DEBOUNCE_CYCLES-1.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 320000;
    localparam int CNT_W_DEFAULT           = 19;

endpackage

// File: rtl/irq_button_ctrl_if.sv
// -----------------------------------------------------------------------------
// irq_button_ctrl_if
// Processor-facing signals of the button interrupt block.
//   interrupt     : level request, held until acknowledged
//   interrupt_ack : one-cycle acknowledge pulse from the core
//   overrun_clr   : one-cycle pulse from a firmware port write
//   press_count   : debounced press counter (wraps)
//   overrun       : sticky "press arrived while a request was still pending"
//
// Handshake: interrupt is raised by the block and stays high until the core
// answers with a one-cycle interrupt_ack; the request drops on the edge that
// samples the ack. An ack seen while no request is pending has no effect. A
// new press arriving in the same cycle as the ack becomes the next request,
// so interrupt then stays high.
//   master : the interrupt source (this block)
//   slave  : the processor / firmware side
// -----------------------------------------------------------------------------
interface irq_button_ctrl_if;
    logic       interrupt;
    logic       interrupt_ack;
    logic       overrun_clr;
    logic [7:0] press_count;
    logic       overrun;

    modport master (
        output interrupt,
        output press_count,
        output overrun,
        input  interrupt_ack,
        input  overrun_clr
    );

    modport slave (
        input  interrupt,
        input  press_count,
        input  overrun,
        output interrupt_ack,
        output overrun_clr
    );
endinterface

// File: rtl/irq_button_ctrl_sync_debounce.sv
// -----------------------------------------------------------------------------
// irq_button_ctrl_sync_debounce
// Two-flop synchroniser followed by a four-state debounce FSM. A level change
// is accepted only after btn_sync holds the new value for DEBOUNCE_CYCLES
// consecutive cycles in the checking state. Written to be reused for the other
// direction buttons and the switches.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   btn_raw     : asynchronous raw input, active-high
//   btn_level   : debounced level (registered)
//   press_pulse : one-cycle pulse on each accepted rising level
//   state       : current debounce state, for observation
// -----------------------------------------------------------------------------
module irq_button_ctrl_sync_debounce
    import irq_button_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       press_pulse,
    output deb_state_t state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             btn_sync;
    deb_state_t       state_q;
    deb_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             pulse_q;
    logic             pulse_d;

    // Plain flop-to-flop chain: nothing may sit between the two stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1       <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            s1       <= btn_raw;
            btn_sync <= s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (btn_sync) begin
                    state_d = CHK_HIGH;
                    cnt_d   = '0;
                end
            end
            CHK_HIGH: begin
                if (!btn_sync) begin
                    // Too short: treat as bounce and start over.
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE_HIGH: begin
                if (!btn_sync) begin
                    state_d = CHK_LOW;
                    cnt_d   = '0;
                end
            end
            CHK_LOW: begin
                if (btn_sync) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Releases update the level but never raise a pulse.
                    state_d = IDLE_LOW;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign btn_level   = level_q;
    assign press_pulse = pulse_q;
    assign state       = state_q;

endmodule

// File: rtl/irq_button_ctrl.sv
// -----------------------------------------------------------------------------
// irq_button_ctrl
// Push-button interrupt source for the PicoBlaze core. Each debounced press
// raises a level interrupt held until interrupt_ack, bumps an 8-bit wrapping
// press counter, and sets a sticky overrun flag if the previous request was
// still pending.
// Ports:
//   clk, rst  : 32 MHz clock, asynchronous active-high reset
//   btn_raw   : raw bouncing button, active-high
//   bus       : processor-facing interrupt / status signals (master side)
//   btn_level : debounced button level
//   deb_state : debounce FSM state, for observation
//   irq_state : interrupt FSM state, for observation
// -----------------------------------------------------------------------------
module irq_button_ctrl
    import irq_button_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_raw,
    irq_button_ctrl_if.master   bus,
    output logic                btn_level,
    output deb_state_t          deb_state,
    output irq_state_t          irq_state
);

    logic       press_pulse;
    irq_state_t irq_q;
    irq_state_t irq_d;
    logic       ovr_q;
    logic       ovr_d;
    logic [7:0] count_q;

    irq_button_ctrl_sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_sync_debounce (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .press_pulse (press_pulse),
        .state       (deb_state)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q   <= IRQ_IDLE;
            ovr_q   <= 1'b0;
            count_q <= 8'd0;
        end else begin
            irq_q   <= irq_d;
            ovr_q   <= ovr_d;
            count_q <= count_q + {7'd0, press_pulse};
        end
    end

    always_comb begin
        irq_d = irq_q;
        ovr_d = ovr_q;
        // Clear first so that a simultaneous set below takes priority.
        if (bus.overrun_clr) begin
            ovr_d = 1'b0;
        end
        case (irq_q)
            IRQ_IDLE: begin
                if (press_pulse) begin
                    irq_d = IRQ_PEND;
                end
            end
            IRQ_PEND: begin
                if (press_pulse) begin
                    // A press alongside an ack is simply the next request,
                    // so only an unacknowledged collision counts as overrun.
                    irq_d = IRQ_PEND;
                    if (!bus.interrupt_ack) begin
                        ovr_d = 1'b1;
                    end
                end else if (bus.interrupt_ack) begin
                    irq_d = IRQ_IDLE;
                end
            end
            default: begin
                irq_d = IRQ_IDLE;
            end
        endcase
    end

    // The request is the state flop itself, so it never sees inputs
    // combinationally.
    assign bus.interrupt   = (irq_q == IRQ_PEND);
    assign bus.overrun     = ovr_q;
    assign bus.press_count = count_q;
    assign irq_state       = irq_q;

endmodule

// File: tb/tb_irq_button_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_button_ctrl
// Directed scenarios plus randomized button/ack/clear traffic for
// irq_button_ctrl with DEBOUNCE_CYCLES=4, CNT_W=3. A behavioural model tracks
// the debounced level as "D+1 consecutive synchronised samples differing from
// the current level flip it", with the interrupt/overrun/count rules applied
// on top; every cycle the DUT outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_irq_button_ctrl;
    import irq_button_ctrl_pkg::*;

    localparam int D = 4;
    localparam int W = 3;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_raw = 1'b0;
    logic       btn_level;
    deb_state_t deb_state;
    irq_state_t irq_state;

    irq_button_ctrl_if bus ();

    always #5 clk = ~clk;

    irq_button_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .bus       (bus.master),
        .btn_level (btn_level),
        .deb_state (deb_state),
        .irq_state (irq_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_s1    = 1'b0;
    bit m_sync  = 1'b0;
    int m_run   = 0;
    bit m_level = 1'b0;
    bit m_pulse = 1'b0;
    bit m_pend  = 1'b0;
    bit m_ovr   = 1'b0;
    int m_count = 0;
    bit m_seen;
    bit m_pulse_old;
    bit m_set;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = 1'b0; m_sync = 1'b0; m_run = 0; m_level = 1'b0;
            m_pulse = 1'b0; m_pend = 1'b0; m_ovr = 1'b0; m_count = 0;
        end else begin
            // two-stage synchroniser delay
            m_seen = m_sync;
            m_sync = m_s1;
            m_s1   = btn_raw;
            // request / status side reacts to last cycle's press pulse
            m_pulse_old = m_pulse;
            m_set = m_pulse_old && m_pend && !bus.interrupt_ack;
            if (m_set) m_ovr = 1'b1;
            else if (bus.overrun_clr) m_ovr = 1'b0;
            if (m_pulse_old) begin
                m_pend  = 1'b1;
                m_count = (m_count + 1) % 256;
            end else if (bus.interrupt_ack) begin
                m_pend = 1'b0;
            end
            // debounce: D+1 consecutive differing samples flip the level
            m_pulse = 1'b0;
            if (m_seen != m_level) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_level = !m_level;
                    m_run   = 0;
                    m_pulse = m_level;
                end
            end else begin
                m_run = 0;
            end
        end
    end

    // ---------------- scoreboard: per-cycle compare ----------------
    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("auto_interrupt",   32'(bus.interrupt),   32'(m_pend));
            check("auto_btn_level",   32'(btn_level),       32'(m_level));
            check("auto_press_count", 32'(bus.press_count), 32'(m_count));
            check("auto_overrun",     32'(bus.overrun),     32'(m_ovr));
        end
    end

    // ---------------- driver tasks ----------------
    bit rnd_ctl = 1'b0;

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rnd_ctl) begin
                bus.interrupt_ack = ($urandom_range(0, 7) == 0);
                bus.overrun_clr   = ($urandom_range(0, 9) == 0);
            end
        end
    endtask

    // Returns at the negedge inside the cycle where the press pulse is high.
    task automatic wait_pulse(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            cycles(1);
            if (m_pulse) ok = 1'b1;
        end
        if (!ok) check({tag, "_pulse_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic release_btn();
        btn_raw = 1'b0;
        cycles(12);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] bounce_pat = 8'b1101_0110;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.interrupt_ack = 1'b0;
        bus.overrun_clr   = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset_interrupt",   32'(bus.interrupt),   32'd0);
        check("reset_btn_level",   32'(btn_level),       32'd0);
        check("reset_press_count", 32'(bus.press_count), 32'd0);
        check("reset_overrun",     32'(bus.overrun),     32'd0);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        cycles(3);

        // Clean press: edge 0 is the next posedge.
        btn_raw = 1'b1;
        cycles(6);
        check("clean_level_e5", 32'(btn_level), 32'd0);
        cycles(1);
        check("clean_level_e6", 32'(btn_level), 32'd1);
        check("clean_irq_e6",   32'(bus.interrupt), 32'd0);
        cycles(1);
        check("clean_irq_e7",   32'(bus.interrupt), 32'd1);
        check("clean_count",    32'(bus.press_count), 32'd1);
        cycles(10);
        check("clean_irq_held", 32'(bus.interrupt), 32'd1);

        // Ack handshake
        bus.interrupt_ack = 1'b1;
        cycles(1);
        bus.interrupt_ack = 1'b0;
        check("ack_irq_low",  32'(bus.interrupt), 32'd0);
        check("ack_overrun",  32'(bus.overrun),   32'd0);
        release_btn();
        check("release_level", 32'(btn_level), 32'd0);

        // Bounce rejection
        for (int i = 7; i >= 0; i--) begin
            btn_raw = bounce_pat[i];
            cycles(1);
        end
        btn_raw = 1'b0;
        cycles(10);
        check("bounce_level", 32'(btn_level),       32'd0);
        check("bounce_irq",   32'(bus.interrupt),   32'd0);
        check("bounce_count", 32'(bus.press_count), 32'd1);

        // Overrun: two presses without ack
        btn_raw = 1'b1;
        wait_pulse("ovr1");
        cycles(1);
        check("ovr_first_irq", 32'(bus.interrupt), 32'd1);
        release_btn();
        btn_raw = 1'b1;
        wait_pulse("ovr2");
        cycles(1);
        check("ovr_irq",     32'(bus.interrupt),   32'd1);
        check("ovr_count",   32'(bus.press_count), 32'd3);
        check("ovr_flag",    32'(bus.overrun),     32'd1);
        bus.overrun_clr = 1'b1;
        cycles(1);
        bus.overrun_clr = 1'b0;
        check("ovr_cleared",     32'(bus.overrun),   32'd0);
        check("ovr_clr_irq_on",  32'(bus.interrupt), 32'd1);
        release_btn();

        // Ack coinciding with a new press (request still pending)
        btn_raw = 1'b1;
        wait_pulse("sim");
        bus.interrupt_ack = 1'b1;
        cycles(1);
        bus.interrupt_ack = 1'b0;
        check("sim_irq",     32'(bus.interrupt),   32'd1);
        check("sim_overrun", 32'(bus.overrun),     32'd0);
        check("sim_count",   32'(bus.press_count), 32'd4);
        release_btn();

        // Overrun set and clear in the same cycle: set wins
        btn_raw = 1'b1;
        wait_pulse("coll");
        bus.overrun_clr = 1'b1;
        cycles(1);
        bus.overrun_clr = 1'b0;
        check("coll_overrun", 32'(bus.overrun),     32'd1);
        check("coll_count",   32'(bus.press_count), 32'd5);

        // Async reset in the middle of CHK_HIGH with a request pending
        release_btn();
        btn_raw = 1'b1;
        cycles(4);
        #2 rst = 1'b1;
        #1;
        check("arst_interrupt",   32'(bus.interrupt),   32'd0);
        check("arst_btn_level",   32'(btn_level),       32'd0);
        check("arst_press_count", 32'(bus.press_count), 32'd0);
        check("arst_overrun",     32'(bus.overrun),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        cycles(7);
        check("post_rst_irq_e6", 32'(bus.interrupt), 32'd0);
        cycles(1);
        check("post_rst_irq_e7", 32'(bus.interrupt), 32'd1);
        check("post_rst_count",  32'(bus.press_count), 32'd1);
        release_btn();

        // Randomized presses with random ack/clear traffic up to the wrap
        rnd_ctl = 1'b1;
        for (int p = 0; p < 254; p++) begin
            btn_raw = 1'b1;
            wait_pulse("rnd_press");
            cycles($urandom_range(1, 5));
            btn_raw = 1'b0;
            cycles($urandom_range(8, 14));
        end
        check("count_255", 32'(bus.press_count), 32'd255);
        btn_raw = 1'b1;
        wait_pulse("wrap");
        cycles(1);
        check("count_wrap", 32'(bus.press_count), 32'd0);
        btn_raw = 1'b0;
        cycles(12);

        // Randomized bouncing with runs straddling the debounce threshold
        for (int r = 0; r < 400; r++) begin
            btn_raw = $urandom_range(0, 1);
            cycles($urandom_range(1, 8));
        end
        rnd_ctl = 1'b0;
        bus.interrupt_ack = 1'b0;
        bus.overrun_clr   = 1'b0;
        cycles(4);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
